// File: rtl/stream_ram.sv
// stream_ram: simple dual-port RAM (one write port, one read port) with a
// valid/ready read-request stream and a valid/ready read-response stream.
//
// Read path: stage 1 is the registered RAM read, with a bypass for a write
// that lands on the same edge. Stages 2..READ_LATENCY are plain registers.
// The last stage acts as the input register of the response buffer. When
// the buffer is empty and the response is taken straight away, the item
// passes through. Otherwise it is parked in the buffer, so no response is
// ever lost. A credit counter (in_flight) keeps the outstanding requests
// within READ_LATENCY+1. The pipeline therefore never stalls and the buffer
// can never overflow.
//
// Coherence: a write on an earlier edge is already in mem_r when stage 1
// reads. A write on the same edge is forwarded only when WRITE_FIRST is set.
// Data is captured at stage 1, so later writes cannot reach a request that
// is already in flight.
module stream_ram #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter string       STYLE        = "block",
  parameter int unsigned READ_LATENCY = 2,
  parameter bit          WRITE_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_resp_valid,
  input  logic                  rd_resp_ready,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic [3:0]            in_flight
);

  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam int unsigned FIFO_DEPTH = READ_LATENCY + 1;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]       CREDITS  = 4'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  // Elaboration-time parameter sanity checks
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("stream_ram: READ_LATENCY must be within 1..8");
  end
  if (STYLE != "block" && STYLE != "ultra") begin : g_bad_style
    $error("stream_ram: STYLE must be \"block\" or \"ultra\"");
  end

  // Circular pointer increment for a buffer whose depth need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Storage and pipeline state
  (* ram_style = STYLE *) logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q_r;
  logic [DATA_WIDTH-1:0] byp_data_r;
  logic                  byp_hit_r;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] s1_data_s;
  logic                  tail_valid_s;
  logic [DATA_WIDTH-1:0] tail_data_s;

  // Response buffer
  logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [3:0]            fifo_cnt_r;
  logic                  fifo_nonempty_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;

  // Handshakes and credits
  logic                  req_fire_s;
  logic                  resp_pop_s;
  logic [3:0]            in_flight_r;
  logic [3:0]            in_flight_nxt_s;
  logic                  ready_r;

  assign req_fire_s      = rd_req_valid & ready_r;
  assign fifo_nonempty_s = (fifo_cnt_r != 4'd0);
  assign rd_resp_valid   = fifo_nonempty_s | tail_valid_s;
  assign resp_pop_s      = rd_resp_valid & rd_resp_ready;

  // RAM write port and synchronous read port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      mem_r[wr_addr] <= wr_data;
    end
    ram_q_r <= mem_r[rd_req_addr];
  end

  // Stage 1 control: request valid plus the same-edge write bypass capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      byp_hit_r  <= 1'b0;
      byp_data_r <= '0;
    end else begin
      s1_valid_r <= req_fire_s;
      byp_hit_r  <= WRITE_FIRST && wr_valid && (wr_addr == rd_req_addr);
      byp_data_r <= wr_data;
    end
  end

  assign s1_data_s = byp_hit_r ? byp_data_r : ram_q_r;

  if (READ_LATENCY == 1) begin : g_lat1
    // The RAM read result is the last stage and feeds the buffer directly
    assign tail_valid_s = s1_valid_r;
    assign tail_data_s  = s1_data_s;
  end else begin : g_latn
    logic [READ_LATENCY-2:0] pv_r;
    logic [DATA_WIDTH-1:0]   pd_r [READ_LATENCY-1];

    // Non-stalling shift pipeline behind the RAM read stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv_r <= '0;
        for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
          pd_r[i] <= '0;
        end
      end else begin
        pv_r[0] <= s1_valid_r;
        pd_r[0] <= s1_data_s;
        for (int i = 1; i < int'(READ_LATENCY) - 1; i++) begin
          pv_r[i] <= pv_r[i-1];
          pd_r[i] <= pd_r[i-1];
        end
      end
    end

    assign tail_valid_s = pv_r[READ_LATENCY-2];
    assign tail_data_s  = pd_r[READ_LATENCY-2];
  end

  // Buffer push/pop decision: the head is the buffer if non-empty, else the last stage
  always_comb begin
    fifo_push_s = 1'b0;
    fifo_pop_s  = 1'b0;
    if (fifo_nonempty_s) begin
      fifo_pop_s  = resp_pop_s;
      fifo_push_s = tail_valid_s;
    end else begin
      fifo_pop_s  = 1'b0;
      fifo_push_s = tail_valid_s & ~resp_pop_s;
    end
  end

  // Response data mux, forced to zero when nothing is presented
  always_comb begin
    rd_resp_data = '0;
    if (fifo_nonempty_s) begin
      rd_resp_data = fifo_mem_r[rd_ptr_r];
    end else if (tail_valid_s) begin
      rd_resp_data = tail_data_s;
    end else begin
      rd_resp_data = '0;
    end
  end

  // Buffer storage; only written at the write pointer on a push
  always_ff @(posedge clk) begin
    if (fifo_push_s) begin
      fifo_mem_r[wr_ptr_r] <= tail_data_s;
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= 4'd0;
    end else begin
      if (fifo_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({fifo_push_s, fifo_pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 4'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 4'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Next credit count: +1 on request accept, -1 on response transfer
  always_comb begin
    in_flight_nxt_s = in_flight_r;
    case ({req_fire_s, resp_pop_s})
      2'b10:   in_flight_nxt_s = in_flight_r + 4'd1;
      2'b01:   in_flight_nxt_s = in_flight_r - 4'd1;
      default: in_flight_nxt_s = in_flight_r;
    endcase
  end

  // Registered credit count and request ready derived from it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_r <= 4'd0;
      ready_r     <= 1'b1;
    end else begin
      in_flight_r <= in_flight_nxt_s;
      ready_r     <= (in_flight_nxt_s < CREDITS);
    end
  end

  assign in_flight    = in_flight_r;
  assign rd_req_ready = ready_r;

endmodule

// File: tb/tb_stream_ram.sv
// tb_stream_ram: four stream_ram instances (READ_LATENCY 1..4, WRITE_FIRST
// alternating 0/1) share the same stimulus. Each instance has its own
// expected-response queue. Directed steps cover reset, streaming, backpressure
// and read/write ordering. A random phase follows.
module tb_stream_ram;

  localparam int ND    = 4;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_ready;
  logic [ND-1:0] rdy;
  logic [ND-1:0] rv;
  logic [DW-1:0] rdat [ND];
  logic [3:0]    infl [ND];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] eq [ND][16];
  int            qh [ND];
  int            qc [ND];
  int            fires [ND];
  int            pops [ND];
  int            first_fire_cyc [ND];
  int            first_pop_cyc [ND];
  int            last_pop_cyc [ND];
  logic [DW-1:0] pop_data [ND][4];
  logic [DW-1:0] last_pop_data [ND];
  logic [ND-1:0] fire_l;
  logic [ND-1:0] stall_l;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    stream_ram #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .STYLE       ("block"),
      .READ_LATENCY(g + 1),
      .WRITE_FIRST (g % 2 == 1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rdy[g]),
      .rd_req_addr  (rd_req_addr),
      .rd_resp_valid(rv[g]),
      .rd_resp_ready(rd_resp_ready),
      .rd_resp_data (rdat[g]),
      .in_flight    (infl[g])
    );
  end

  function automatic bit wf(input int d);
    return (d % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    for (int d = 0; d < ND; d++) begin
      fires[d] = 0;
      pops[d]  = 0;
    end
  endtask

  task automatic clr_models();
    for (int d = 0; d < ND; d++) begin
      qh[d] = 0;
      qc[d] = 0;
    end
    stall_l = '0;
  endtask

  // One clock: sample handshakes, score responses, model requests/writes, advance
  task automatic step();
    logic [DW-1:0] e;
    for (int d = 0; d < ND; d++) begin
      if (stall_l[d]) chk($sformatf("resp_hold%0d", d), rv[d], 1);
      stall_l[d] = rv[d] && !rd_resp_ready;
      fire_l[d]  = rd_req_valid && rdy[d];
      if (rv[d] && rd_resp_ready) begin
        chk($sformatf("resp_expected%0d", d), qc[d] != 0, 1);
        if (qc[d] != 0) begin
          chk($sformatf("resp_data%0d", d), rdat[d], eq[d][qh[d]]);
          qh[d] = (qh[d] + 1) % 16;
          qc[d]--;
        end
        if (pops[d] == 0) first_pop_cyc[d] = cyc;
        if (pops[d] < 4) pop_data[d][pops[d]] = rdat[d];
        last_pop_cyc[d]  = cyc;
        last_pop_data[d] = rdat[d];
        pops[d]++;
      end
      if (fire_l[d]) begin
        e = (wf(d) && wr_valid && wr_addr == rd_req_addr) ? wr_data : mm[rd_req_addr];
        eq[d][(qh[d] + qc[d]) % 16] = e;
        qc[d]++;
        if (fires[d] == 0) first_fire_cyc[d] = cyc;
        fires[d]++;
      end
    end
    if (wr_valid) mm[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst           = 1'b1;
    wr_valid      = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    rd_req_valid  = 1'b0;
    rd_req_addr   = '0;
    rd_resp_ready = 1'b1;
    fire_l        = '0;
    clr_models();
    clr_stats();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_in_flight%0d", d), infl[d], 0);
      chk($sformatf("rst_resp_valid%0d", d), rv[d], 0);
      chk($sformatf("rst_req_ready%0d", d), rdy[d], 1);
      chk($sformatf("rst_resp_data%0d", d), rdat[d], 0);
    end
    rst = 1'b0;

    // Fill: mem[k] = k*3
    for (int k = 0; k < DEPTH; k++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(k);
      wr_data  = DW'(k * 3);
      step();
    end
    wr_valid = 1'b0;

    // Reset mid-stream with requests outstanding
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_addr   = AW'(10);
    repeat (3) step();
    rd_req_valid = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("pre_rst_in_flight%0d", d), infl[d], (d == 0) ? 2 : 3);
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("mid_rst_in_flight%0d", d), infl[d], 0);
      chk($sformatf("mid_rst_resp_valid%0d", d), rv[d], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_models();
    rd_resp_ready = 1'b1;
    repeat (10) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("post_rst_resp_valid%0d", d), rv[d], 0);
      chk($sformatf("post_rst_req_ready%0d", d), rdy[d], 1);
    end

    // Streaming: 1024 back-to-back reads with ready held high
    clr_stats();
    rd_req_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      rd_req_addr = AW'(k);
      step();
    end
    rd_req_valid = 1'b0;
    repeat (12) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("stream_fires%0d", d), fires[d], DEPTH);
      chk($sformatf("stream_pops%0d", d), pops[d], DEPTH);
      chk($sformatf("stream_latency%0d", d), first_pop_cyc[d] - first_fire_cyc[d], d + 1);
      chk($sformatf("stream_rate%0d", d), last_pop_cyc[d] - first_pop_cyc[d], DEPTH - 1);
      chk($sformatf("stream_first%0d", d), pop_data[d][1], 3);
      chk($sformatf("stream_last%0d", d), last_pop_data[d], 3069);
    end

    // Backpressure: response ready low for 20 cycles, requests pending
    clr_stats();
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_addr   = AW'(200);
    repeat (20) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("bp_accepts%0d", d), fires[d], d + 2);
      chk($sformatf("bp_req_ready%0d", d), rdy[d], 0);
      chk($sformatf("bp_in_flight%0d", d), infl[d], d + 2);
      chk($sformatf("bp_resp_valid%0d", d), rv[d], 1);
    end
    rd_resp_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (fire_l == {ND{1'b1}}) break;
    end
    rd_req_valid = 1'b0;
    repeat (15) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("bp_no_loss%0d", d), pops[d], fires[d]);
      chk($sformatf("bp_drained%0d", d), infl[d], 0);
      chk($sformatf("bp_data%0d", d), last_pop_data[d], 600);
    end

    // Same-cycle read-after-write on address 5
    wr_valid = 1'b1;
    wr_addr  = AW'(5);
    wr_data  = 32'h0000_000A;
    step();
    clr_stats();
    wr_data      = 32'h0000_000B;
    rd_req_valid = 1'b1;
    rd_req_addr  = AW'(5);
    step();
    wr_valid = 1'b0;
    step();
    rd_req_valid = 1'b0;
    repeat (12) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("raw_pops%0d", d), pops[d], 2);
      chk($sformatf("raw_same%0d", d), pop_data[d][0], wf(d) ? 32'h0000_000B : 32'h0000_000A);
      chk($sformatf("raw_next%0d", d), pop_data[d][1], 32'h0000_000B);
    end

    // Write-after-read on address 7 (old word is 21)
    clr_stats();
    rd_req_valid = 1'b1;
    rd_req_addr  = AW'(7);
    step();
    rd_req_valid = 1'b0;
    wr_valid     = 1'b1;
    wr_addr      = AW'(7);
    wr_data      = 32'h0000_000C;
    repeat (4) step();
    wr_valid     = 1'b0;
    rd_req_valid = 1'b1;
    step();
    rd_req_valid = 1'b0;
    repeat (12) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("war_old%0d", d), pop_data[d][0], 21);
      chk($sformatf("war_new%0d", d), pop_data[d][1], 32'h0000_000C);
    end

    // Random traffic on a narrow address range to force collisions
    clr_stats();
    for (int n = 0; n < 3000; n++) begin
      wr_valid      = ($urandom_range(0, 1) == 1);
      wr_addr       = AW'($urandom_range(0, 15));
      wr_data       = $urandom();
      rd_resp_ready = ($urandom_range(0, 3) != 0);
      if (!rd_req_valid || fire_l == {ND{1'b1}}) begin
        rd_req_valid = ($urandom_range(0, 2) != 0);
        rd_req_addr  = AW'($urandom_range(0, 15));
      end
      step();
    end
    wr_valid      = 1'b0;
    rd_resp_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (!rd_req_valid) break;
      step();
      if (fire_l == {ND{1'b1}}) rd_req_valid = 1'b0;
    end
    rd_req_valid = 1'b0;
    repeat (15) step();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rand_no_loss%0d", d), pops[d], fires[d]);
      chk($sformatf("rand_queue_empty%0d", d), qc[d], 0);
      chk($sformatf("rand_in_flight%0d", d), infl[d], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
